// File: rtl/msrh_lsu_pkg.sv
// Shared LSU-side types and default sizing for the L2 request path.
// The arbiter takes its parameter defaults from here so that every instance sizes the same way.
package msrh_lsu_pkg;

    localparam int L2_N_CH   = 4;
    localparam int L2_REQ_W  = 128;
    localparam int L2_RESP_W = 576;
    localparam int L2_TAG_W  = 4;
    localparam int L2_OUTST  = 8;
    localparam int L2_OT_W   = $clog2(L2_OUTST);
    localparam int L2_CH_W   = $clog2(L2_N_CH);

    typedef logic [L2_REQ_W-1:0]  l2_req_t;
    typedef logic [L2_RESP_W-1:0] l2_resp_t;

    // Outstanding-table entry at the default sizing.
    typedef struct packed {
        logic                vld;
        logic [L2_CH_W-1:0]  ch;
        logic [L2_TAG_W-1:0] tag;
    } l2_arb_entry_t;

endpackage

// File: rtl/msrh_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after i_ptr (wrapping) wins.
// Purely combinational; the caller owns and advances the pointer.
module msrh_rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_grant_vld
);

    int cand;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        cand        = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(i_ptr) + i) % N;
            if (!o_grant_vld && i_req[cand]) begin
                o_grant_vld = 1'b1;
                o_grant     = '0;
                o_grant[cand] = 1'b1;
                o_grant_idx = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/msrh_l2_req_arbiter.sv
// Multiplexes N upstream requesters onto one registered L2 request stage, swapping each
// upstream tag for an outstanding-table index and routing responses back by that index.
module msrh_l2_req_arbiter
    import msrh_lsu_pkg::*;
#(
    parameter  int N_CH   = L2_N_CH,
    parameter  int REQ_W  = L2_REQ_W,
    parameter  int RESP_W = L2_RESP_W,
    parameter  int TAG_W  = L2_TAG_W,
    parameter  int OUTST  = L2_OUTST,
    localparam int OT_W   = $clog2(OUTST),
    localparam int CH_W   = $clog2(N_CH)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,

    input  logic [N_CH-1:0]        i_req_valid,
    output logic [N_CH-1:0]        o_req_ready,
    input  logic [N_CH*REQ_W-1:0]  i_req_payload,
    input  logic [N_CH*TAG_W-1:0]  i_req_tag,

    output logic                   o_l2_req_valid,
    input  logic                   i_l2_req_ready,
    output logic [REQ_W-1:0]       o_l2_req_payload,
    output logic [OT_W-1:0]        o_l2_req_tag,

    input  logic                   i_l2_resp_valid,
    output logic                   o_l2_resp_ready,
    input  logic [RESP_W-1:0]      i_l2_resp_payload,
    input  logic [OT_W-1:0]        i_l2_resp_tag,

    output logic [N_CH-1:0]        o_resp_valid,
    input  logic [N_CH-1:0]        i_resp_ready,
    output logic [RESP_W-1:0]      o_resp_payload,
    output logic [TAG_W-1:0]       o_resp_tag,

    output logic [OT_W:0]          o_outst_cnt,
    output logic                   o_err_unexp_resp
);

    typedef struct packed {
        logic             vld;
        logic [CH_W-1:0]  ch;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t             tbl_q [OUTST];
    logic [CH_W-1:0]    ptr_q;
    logic [OT_W:0]      cnt_q;
    logic               err_q;
    logic               l2_req_valid_q;
    logic [REQ_W-1:0]   l2_req_payload_q;
    logic [OT_W-1:0]    l2_req_tag_q;

    logic               have_free;
    logic [OT_W-1:0]    alloc_idx;
    logic               can_issue;
    logic [N_CH-1:0]    arb_req;
    logic [N_CH-1:0]    grant;
    logic [CH_W-1:0]    grant_idx;
    logic               grant_vld;

    entry_t             resp_e;
    logic               resp_free;
    logic               resp_unexp;

    // Lowest-index free entry; scanning downward leaves the smallest hit in alloc_idx.
    always_comb begin
        have_free = 1'b0;
        alloc_idx = '0;
        for (int i = OUTST - 1; i >= 0; i--) begin
            if (!tbl_q[i].vld) begin
                have_free = 1'b1;
                alloc_idx = OT_W'(i);
            end
        end
    end

    assign can_issue = (!l2_req_valid_q || i_l2_req_ready) && have_free;
    assign arb_req   = i_req_valid & {N_CH{can_issue}};

    msrh_rr_arbiter #(
        .N (N_CH)
    ) u_rr_arb (
        .i_req       (arb_req),
        .i_ptr       (ptr_q),
        .o_grant     (grant),
        .o_grant_idx (grant_idx),
        .o_grant_vld (grant_vld)
    );

    assign o_req_ready = grant;

    // Response routing looks only at the pre-update table, so a same-cycle alloc never aliases.
    assign resp_e = tbl_q[i_l2_resp_tag];

    always_comb begin
        o_resp_valid = '0;
        if (resp_e.vld && i_l2_resp_valid) begin
            o_resp_valid[resp_e.ch] = 1'b1;
        end
    end

    assign o_l2_resp_ready = resp_e.vld ? i_resp_ready[resp_e.ch] : 1'b1;
    assign o_resp_tag      = resp_e.tag;
    assign o_resp_payload  = i_l2_resp_payload;
    assign resp_free       = i_l2_resp_valid && resp_e.vld && i_resp_ready[resp_e.ch];
    assign resp_unexp      = i_l2_resp_valid && !resp_e.vld;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < OUTST; i++) begin
                tbl_q[i] <= '0;
            end
            ptr_q            <= '0;
            cnt_q            <= '0;
            err_q            <= 1'b0;
            l2_req_valid_q   <= 1'b0;
            l2_req_payload_q <= '0;
            l2_req_tag_q     <= '0;
        end else begin
            if (resp_free) begin
                tbl_q[i_l2_resp_tag].vld <= 1'b0;
            end

            if (grant_vld) begin
                tbl_q[alloc_idx].vld <= 1'b1;
                tbl_q[alloc_idx].ch  <= grant_idx;
                tbl_q[alloc_idx].tag <= i_req_tag[grant_idx*TAG_W +: TAG_W];
                ptr_q <= (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + CH_W'(1);
            end

            if (grant_vld) begin
                l2_req_valid_q   <= 1'b1;
                l2_req_payload_q <= i_req_payload[grant_idx*REQ_W +: REQ_W];
                l2_req_tag_q     <= alloc_idx;
            end else if (i_l2_req_ready) begin
                l2_req_valid_q   <= 1'b0;
                l2_req_payload_q <= '0;
                l2_req_tag_q     <= '0;
            end

            case ({grant_vld, resp_free})
                2'b10:   cnt_q <= cnt_q + (OT_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (OT_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase

            if (resp_unexp) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_l2_req_valid   = l2_req_valid_q;
    assign o_l2_req_payload = l2_req_payload_q;
    assign o_l2_req_tag     = l2_req_tag_q;
    assign o_outst_cnt      = cnt_q;
    assign o_err_unexp_resp = err_q;

endmodule

// File: tb/tb_msrh_l2_req_arbiter.sv
// Directed bench for msrh_l2_req_arbiter at default sizing (4 channels, 8 table entries).
module tb_msrh_l2_req_arbiter;

    localparam int N_CH   = 4;
    localparam int REQ_W  = 128;
    localparam int RESP_W = 576;
    localparam int TAG_W  = 4;
    localparam int OUTST  = 8;
    localparam int OT_W   = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH-1:0]        req_valid;
    logic [N_CH-1:0]        req_ready;
    logic [N_CH*REQ_W-1:0]  req_payload;
    logic [N_CH*TAG_W-1:0]  req_tag;
    logic                   l2_req_valid;
    logic                   l2_req_ready;
    logic [REQ_W-1:0]       l2_req_payload;
    logic [OT_W-1:0]        l2_req_tag;
    logic                   l2_resp_valid;
    logic                   l2_resp_ready;
    logic [RESP_W-1:0]      l2_resp_payload;
    logic [OT_W-1:0]        l2_resp_tag;
    logic [N_CH-1:0]        resp_valid;
    logic [N_CH-1:0]        resp_ready;
    logic [RESP_W-1:0]      resp_payload;
    logic [TAG_W-1:0]       resp_tag;
    logic [OT_W:0]          outst_cnt;
    logic                   err_unexp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    msrh_l2_req_arbiter #(
        .N_CH   (N_CH),
        .REQ_W  (REQ_W),
        .RESP_W (RESP_W),
        .TAG_W  (TAG_W),
        .OUTST  (OUTST)
    ) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_req_valid       (req_valid),
        .o_req_ready       (req_ready),
        .i_req_payload     (req_payload),
        .i_req_tag         (req_tag),
        .o_l2_req_valid    (l2_req_valid),
        .i_l2_req_ready    (l2_req_ready),
        .o_l2_req_payload  (l2_req_payload),
        .o_l2_req_tag      (l2_req_tag),
        .i_l2_resp_valid   (l2_resp_valid),
        .o_l2_resp_ready   (l2_resp_ready),
        .i_l2_resp_payload (l2_resp_payload),
        .i_l2_resp_tag     (l2_resp_tag),
        .o_resp_valid      (resp_valid),
        .i_resp_ready      (resp_ready),
        .o_resp_payload    (resp_payload),
        .o_resp_tag        (resp_tag),
        .o_outst_cnt       (outst_cnt),
        .o_err_unexp_resp  (err_unexp)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_resp(input logic v, input logic [OT_W-1:0] idx, input logic [N_CH-1:0] rdy);
        l2_resp_valid = v;
        l2_resp_tag   = idx;
        resp_ready    = rdy;
    endtask

    // Table owners after the fill phase (pointer starts at 1): idx i -> ch (i+1)%4.
    int order [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

    initial begin
        rst             = 1'b1;
        req_valid       = '0;
        req_payload     = '0;
        req_tag         = {4'd12, 4'd9, 4'd7, 4'd3};
        l2_req_ready    = 1'b1;
        l2_resp_payload = '0;
        set_resp(1'b0, '0, '0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_l2_vld", l2_req_valid, 0);
        chk("rst_cnt", outst_cnt, 0);
        chk("rst_err", err_unexp, 0);
        rst = 1'b0;

        // Single request, then its response.
        req_payload[0 +: REQ_W] = 'hA5;
        req_valid = 4'b0001;
        #1 chk("t1_grant", req_ready, 4'b0001);
        chk("t1_vld_pre", l2_req_valid, 0);
        step();
        req_valid = '0;
        chk("t1_l2_vld", l2_req_valid, 1);
        chk("t1_l2_tag", l2_req_tag, 0);
        chk("t1_l2_pay", l2_req_payload, 'hA5);
        chk("t1_cnt", outst_cnt, 1);
        step();
        chk("t1_l2_clr", l2_req_valid, 0);
        l2_resp_payload[127:0] = 'hDEADBEEF;
        set_resp(1'b1, 3'd0, 4'b0001);
        #1 chk("t1_rvld", resp_valid, 4'b0001);
        chk("t1_rtag", resp_tag, 3);
        chk("t1_rrdy", l2_resp_ready, 1);
        chk("t1_rpay", resp_payload[127:0], 'hDEADBEEF);
        step();
        set_resp(1'b0, '0, '0);
        chk("t1_cnt0", outst_cnt, 0);

        // Fill: all channels valid, one grant per cycle until the table is full.
        for (int k = 0; k < N_CH; k++) req_payload[k*REQ_W +: REQ_W] = REQ_W'(256 + k);
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1 chk("t2_grant", req_ready, 4'b0001 << order[i]);
            step();
            chk("t2_tag", l2_req_tag, i);
            chk("t2_pay", l2_req_payload, 256 + order[i]);
        end
        #1 chk("t2_full_nogrant", req_ready, 0);
        chk("t2_cnt", outst_cnt, 8);
        step();
        chk("t2_drain", l2_req_valid, 0);
        chk("t2_cnt_hold", outst_cnt, 8);

        // Full table: idx5 (ch2, tag 9) answered; no grant until the next cycle.
        set_resp(1'b1, 3'd5, 4'b0100);
        #1 chk("t3_rvld", resp_valid, 4'b0100);
        chk("t3_rtag", resp_tag, 9);
        chk("t3_rrdy", l2_resp_ready, 1);
        chk("t3_nogrant", req_ready, 0);
        step();
        set_resp(1'b0, '0, '0);
        chk("t3_cnt7", outst_cnt, 7);
        #1 chk("t3_grant_ch1", req_ready, 4'b0010);
        step();
        chk("t3_reuse5", l2_req_tag, 5);
        chk("t3_cnt8", outst_cnt, 8);
        // Free idx2 (ch3, tag 12) while full, then free idx3 with a simultaneous grant.
        set_resp(1'b1, 3'd2, 4'b1000);
        #1 chk("t3_rvld2", resp_valid, 4'b1000);
        chk("t3_rtag2", resp_tag, 12);
        chk("t3_nogrant2", req_ready, 0);
        step();
        chk("t3_cnt7b", outst_cnt, 7);
        set_resp(1'b1, 3'd3, 4'b0001);
        #1 chk("t3_rvld3", resp_valid, 4'b0001);
        chk("t3_grant_ch2", req_ready, 4'b0100);
        step();
        set_resp(1'b0, '0, '0);
        chk("t3_alloc2", l2_req_tag, 2);
        chk("t3_cnt_net", outst_cnt, 7);
        #1 chk("t3_grant_ch3", req_ready, 4'b1000);
        step();
        chk("t3_alloc3", l2_req_tag, 3);
        chk("t3_pay3", l2_req_payload, 256 + 3);
        chk("t3_cnt8b", outst_cnt, 8);

        // L2 stall with a free entry available: stage holds, no grants.
        l2_req_ready = 1'b0;
        set_resp(1'b1, 3'd0, 4'b0010);
        #1 chk("t4_rvld", resp_valid, 4'b0010);
        chk("t4_rtag", resp_tag, 7);
        step();
        set_resp(1'b0, '0, '0);
        for (int c = 0; c < 3; c++) begin
            #1 chk("t4_stall_nogrant", req_ready, 0);
            chk("t4_stall_vld", l2_req_valid, 1);
            chk("t4_stall_tag", l2_req_tag, 3);
            chk("t4_stall_pay", l2_req_payload, 256 + 3);
            step();
        end
        l2_req_ready = 1'b1;
        #1 chk("t4_grant_ch0", req_ready, 4'b0001);
        step();
        chk("t4_tag0", l2_req_tag, 0);
        chk("t4_pay0", l2_req_payload, 256);
        chk("t4_cnt8", outst_cnt, 8);
        // Channel backpressure: response not accepted, entry kept.
        set_resp(1'b1, 3'd1, 4'b0000);
        #1 chk("t4_bp_rrdy", l2_resp_ready, 0);
        chk("t4_bp_rvld", resp_valid, 4'b0100);
        step();
        set_resp(1'b0, '0, '0);
        chk("t4_bp_cnt", outst_cnt, 8);

        // Unexpected response to a freed index.
        req_valid = '0;
        set_resp(1'b1, 3'd6, 4'b1000);
        step();
        chk("t5_cnt7", outst_cnt, 7);
        set_resp(1'b1, 3'd6, 4'b0000);
        #1 chk("t5_rrdy", l2_resp_ready, 1);
        chk("t5_rvld", resp_valid, 0);
        chk("t5_err_pre", err_unexp, 0);
        step();
        set_resp(1'b0, '0, '0);
        chk("t5_err", err_unexp, 1);
        step();
        chk("t5_err_sticky", err_unexp, 1);
        chk("t5_cnt_hold", outst_cnt, 7);

        // Reset with entries outstanding.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_cnt", outst_cnt, 0);
        chk("t6_l2_vld", l2_req_valid, 0);
        chk("t6_err_clr", err_unexp, 0);
        set_resp(1'b1, 3'd1, 4'b0100);
        #1 chk("t6_rvld", resp_valid, 0);
        chk("t6_rrdy", l2_resp_ready, 1);
        step();
        set_resp(1'b0, '0, '0);
        chk("t6_err", err_unexp, 1);
        req_valid = 4'b0100;
        #1 chk("t6_grant_ch2", req_ready, 4'b0100);
        step();
        req_valid = '0;
        chk("t6_tag0", l2_req_tag, 0);
        chk("t6_pay", l2_req_payload, 256 + 2);
        chk("t6_cnt1", outst_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
